conv2d_mac_engine: RTL and testbench

//   Downstream consumer of the activation (9x9) and filter (3x3) buffers. On start it

---
 rtl/conv2d_mac_engine.sv | 143 ++++++++++++++
 tb/tb_conv2d_mac_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/conv2d_mac_engine.sv
// rtl/conv2d_mac_engine.sv - valid-mode 2D convolution MAC engine over 9x9 activations and a 3x3 filter
module conv2d_mac_engine #(
  parameter int IMG_W  = 9,
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ACT_AW = 7,
  parameter int FLT_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ACT_AW-1:0] act_addr,
  input  logic [DATA_W-1:0] act_data,
  output logic [FLT_AW-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int KC_W  = $clog2(K);
  localparam int TAP_W = $clog2(K * K);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  // Sweep position: output (r,c) and tap (i,j) currently being issued
  logic [2:0]      r, c;
  logic [KC_W-1:0] i, j;
  logic            last_r, last_c, last_i, last_j, issue_last;
  logic [TAP_W-1:0] tap_idx;

  // Copy of the issue tags, aligned with the returned buffer data
  logic             d_valid;
  logic [TAP_W-1:0] d_tap;
  logic [2:0]       d_r, d_c;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, acc, acc_sum;

  assign last_r     = (r == 3'(OUT_W - 1));
  assign last_c     = (c == 3'(OUT_W - 1));
  assign last_i     = (i == KC_W'(K - 1));
  assign last_j     = (j == KC_W'(K - 1));
  assign issue_last = (state == S_RUN) && last_r && last_c && last_i && last_j;
  assign tap_idx    = TAP_W'(i) * TAP_W'(K) + TAP_W'(j);

  assign prod     = $signed(act_data) * $signed(flt_data);
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, status flags and read addresses
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    act_addr  = '0;
    flt_addr  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        act_addr = (ACT_AW'(r) + ACT_AW'(i)) * ACT_AW'(IMG_W) + ACT_AW'(c) + ACT_AW'(j);
        flt_addr = FLT_AW'(i) * FLT_AW'(K) + FLT_AW'(j);
        if (issue_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_valid && out_row == 3'(OUT_W - 1) && out_col == 3'(OUT_W - 1))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster sweep counters: j fastest, then i, then c, then r; parked at 0 outside RUN
  always_ff @(posedge clk) begin
    if (rst || state != S_RUN) begin
      r <= '0;
      c <= '0;
      i <= '0;
      j <= '0;
    end else begin
      j <= last_j ? '0 : j + 1'b1;
      if (last_j) begin
        i <= last_i ? '0 : i + 1'b1;
        if (last_i) begin
          c <= last_c ? '0 : c + 3'd1;
          if (last_c) r <= last_r ? '0 : r + 3'd1;
        end
      end
    end
  end

  // Tag pipeline and multiply-accumulate on returned data; tap 0 loads, last tap emits
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_tap     <= '0;
      d_r       <= '0;
      d_c       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      d_valid   <= (state == S_RUN);
      d_tap     <= tap_idx;
      d_r       <= r;
      d_c       <= c;
      out_valid <= 1'b0;
      if (d_valid) begin
        acc <= (d_tap == '0) ? prod_ext : acc_sum;
        if (d_tap == TAP_W'(K * K - 1)) begin
          out_data  <= acc_sum;
          out_valid <= 1'b1;
          out_row   <= d_r;
          out_col   <= d_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_mac_engine.sv
// tb/tb_conv2d_mac_engine.sv - directed self-checking bench for conv2d_mac_engine
module tb_conv2d_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic [6:0]  act_addr;
  logic [7:0]  act_data = '0;
  logic [3:0]  flt_addr;
  logic [7:0]  flt_data = '0;
  logic        out_valid;
  logic [19:0] out_data;
  logic [2:0]  out_row, out_col;
  logic        done;

  conv2d_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .act_addr(act_addr), .act_data(act_data),
    .flt_addr(flt_addr), .flt_data(flt_data),
    .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer models: one-cycle registered read
  logic [7:0] act_mem [128];
  logic [7:0] flt_mem [16];
  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    flt_data <= flt_mem[flt_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Capture results of one run
  int                 np, ndone, done_cyc;
  int                 pcyc [64];
  logic signed [19:0] pdata [64];
  int                 prow [64], pcol [64];
  logic               busy_201, busy_442, busy_443, busy_end;
  logic [6:0]         aa10, aa441;
  logic [3:0]         fa10, fa441;
  logic [19:0]        d18;

  task automatic fill(input int mode);
    for (int n = 0; n < 128; n++) begin
      case (mode)
        1:       act_mem[n] = 8'd1;
        2:       act_mem[n] = 8'(n);
        default: act_mem[n] = 8'h80;
      endcase
    end
    for (int n = 0; n < 16; n++) begin
      case (mode)
        1:       flt_mem[n] = 8'd1;
        2:       flt_mem[n] = (n == 4) ? 8'd1 : 8'd0;
        3:       flt_mem[n] = 8'h80;
        default: flt_mem[n] = 8'h7f;
      endcase
    end
  endtask

  // Start a run and observe 460 cycles; cycle 0 is the first RUN cycle
  task automatic capture(input int restart_a, input int restart_b, input int rst_at);
    np = 0; ndone = 0; done_cyc = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 460; n++) begin
      if (out_valid) begin
        if (np < 64) begin
          pcyc[np] = n; pdata[np] = out_data; prow[np] = int'(out_row); pcol[np] = int'(out_col);
        end
        np++;
      end
      if (done) begin ndone++; done_cyc = n; end
      if (n == 10)  begin aa10 = act_addr; fa10 = flt_addr; end
      if (n == 18)  d18 = out_data;
      if (n == 201) busy_201 = busy;
      if (n == 441) begin aa441 = act_addr; fa441 = flt_addr; end
      if (n == 442) busy_442 = busy;
      if (n == 443) busy_443 = busy;
      if (n == 459) busy_end = busy;
      start = (n == restart_a || n == restart_b);
      rst   = (n == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, out_valid, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, out_valid, done}); end
    n_cmp++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if ({out_row, out_col} !== 6'd0) begin n_fail++; $display("FAIL reset_tags got %0d,%0d want 0,0", out_row, out_col); end
    n_cmp++; if ({act_addr, flt_addr} !== 11'd0) begin n_fail++; $display("FAIL reset_addr got %0d,%0d want 0,0", act_addr, flt_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones;
    fill(1);
    capture(-1, -1, -1);
    n_cmp++; if (np !== 49) begin n_fail++; $display("FAIL ones_count got %0d want 49", np); end
    for (int k = 0; k < 49 && k < np; k++) begin
      n_cmp++; if (pcyc[k] !== 9*k + 10) begin n_fail++; $display("FAIL ones_cycle k=%0d got %0d want %0d", k, pcyc[k], 9*k + 10); end
      n_cmp++; if (prow[k] !== k/7 || pcol[k] !== k%7) begin n_fail++; $display("FAIL ones_tag k=%0d got %0d,%0d want %0d,%0d", k, prow[k], pcol[k], k/7, k%7); end
      n_cmp++; if (pdata[k] !== 20'sd9) begin n_fail++; $display("FAIL ones_data k=%0d got %0d want 9", k, pdata[k]); end
    end
    n_cmp++; if (ndone !== 1 || done_cyc !== 443) begin n_fail++; $display("FAIL ones_done got n=%0d cyc=%0d want n=1 cyc=443", ndone, done_cyc); end
    n_cmp++; if (busy_442 !== 1'b1 || busy_443 !== 1'b0) begin n_fail++; $display("FAIL ones_busy got %b%b want 10", busy_442, busy_443); end
    n_cmp++; if (aa10 !== 7'd2 || fa10 !== 4'd1) begin n_fail++; $display("FAIL addr_c10 got %0d,%0d want 2,1", aa10, fa10); end
    n_cmp++; if (aa441 !== 7'd0 || fa441 !== 4'd0) begin n_fail++; $display("FAIL addr_drain got %0d,%0d want 0,0", aa441, fa441); end
  endtask

  task automatic test_center_tap;
    logic signed [19:0] e;
    fill(2);
    capture(-1, -1, -1);
    n_cmp++; if (np !== 49) begin n_fail++; $display("FAIL center_count got %0d want 49", np); end
    for (int k = 0; k < 49 && k < np; k++) begin
      e = 20'((k/7 + 1)*9 + k%7 + 1);
      n_cmp++; if (pdata[k] !== e) begin n_fail++; $display("FAIL center_data k=%0d got %0d want %0d", k, pdata[k], e); end
    end
    n_cmp++; if (d18 !== 20'd10) begin n_fail++; $display("FAIL center_hold got %0d want 10", d18); end
  endtask

  task automatic test_extremes(input int mode, input logic signed [19:0] e);
    fill(mode);
    capture(-1, -1, -1);
    n_cmp++; if (np !== 49) begin n_fail++; $display("FAIL extreme%0d_count got %0d want 49", mode, np); end
    for (int k = 0; k < 49 && k < np; k++) begin
      n_cmp++; if (pdata[k] !== e) begin n_fail++; $display("FAIL extreme%0d_data k=%0d got %0d want %0d", mode, k, pdata[k], e); end
    end
  endtask

  task automatic test_start_ignored;
    fill(1);
    capture(100, 443, -1);
    n_cmp++; if (np !== 49) begin n_fail++; $display("FAIL restart_count got %0d want 49", np); end
    n_cmp++; if (ndone !== 1 || done_cyc !== 443) begin n_fail++; $display("FAIL restart_done got n=%0d cyc=%0d want n=1 cyc=443", ndone, done_cyc); end
    n_cmp++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL restart_idle got busy=%b want 0", busy_end); end
  endtask

  task automatic test_mid_reset;
    fill(1);
    capture(-1, -1, 200);
    n_cmp++; if (np !== 22) begin n_fail++; $display("FAIL abort_count got %0d want 22", np); end
    n_cmp++; if (np > 0 && pcyc[(np > 64 ? 64 : np) - 1] !== 199) begin n_fail++; $display("FAIL abort_last got %0d want 199", pcyc[(np > 64 ? 64 : np) - 1]); end
    n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", ndone); end
    n_cmp++; if (busy_201 !== 1'b0 || busy_end !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b%b want 00", busy_201, busy_end); end
    capture(-1, -1, -1);
    n_cmp++; if (np !== 49) begin n_fail++; $display("FAIL rerun_count got %0d want 49", np); end
    n_cmp++; if (np > 0 && (pcyc[0] !== 10 || prow[0] !== 0 || pcol[0] !== 0 || pdata[0] !== 20'sd9)) begin n_fail++; $display("FAIL rerun_first got cyc=%0d tag=%0d,%0d data=%0d want 10 0,0 9", pcyc[0], prow[0], pcol[0], pdata[0]); end
    n_cmp++; if (ndone !== 1 || done_cyc !== 443) begin n_fail++; $display("FAIL rerun_done got n=%0d cyc=%0d want n=1 cyc=443", ndone, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_center_tap();
    test_extremes(3, 20'sd147456);
    test_extremes(4, -20'sd146304);
    test_start_ignored();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
